// File: rtl/iob_ram_t2p_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iob_ram_t2p_fifo_ctrl: FIFO controller driving an external t2p RAM.      |
// | Optional first-word-fall-through: IOB_RAM_T2P_FIFO_CTRL_FWFT_EN          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module iob_ram_t2p_fifo_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              rst_i,
  input  logic              w_en_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_full_o,
  input  logic              r_en_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic              r_valid_o,
  output logic              r_empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              ext_mem_w_en_o,
  output logic [ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [DATA_W-1:0] ext_mem_w_data_o,
  output logic              ext_mem_r_en_o,
  output logic [ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [DATA_W-1:0] ext_mem_r_data_i
);

  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] C_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            w_acc;
  logic            r_acc;
  logic            lvl_inc;
  logic            lvl_dec;

  assign w_full_o = (level_q == C_DEPTH);
  assign level_o  = level_q;
  assign w_acc    = w_en_i & ~w_full_o;

  assign ext_mem_w_en_o   = w_acc;
  assign ext_mem_w_addr_o = wptr_q[ADDR_W-1:0];
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = r_acc;
  assign ext_mem_r_addr_o = rptr_q[ADDR_W-1:0];

  // The RAM output register is the data path in both modes.
  assign r_data_o = ext_mem_r_data_i;

`ifdef IOB_RAM_T2P_FIFO_CTRL_FWFT_EN
  logic head_valid_q, head_valid_d;
  logic pop;

  assign pop = r_en_i & head_valid_q;
  // Prefetch whenever the RAM has unread words and the head slot frees up.
  assign r_acc     = (wptr_q != rptr_q) & (~head_valid_q | pop);
  assign r_valid_o = head_valid_q;
  assign r_empty_o = ~head_valid_q;
  assign lvl_inc   = w_acc;
  assign lvl_dec   = pop;

  always_comb begin
    head_valid_d = r_acc | (head_valid_q & ~pop);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      head_valid_q <= 1'b0;
    end else if (rst_i) begin
      head_valid_q <= 1'b0;
    end else begin
      head_valid_q <= head_valid_d;
    end
  end
`else
  logic r_valid_q, r_valid_d;

  assign r_empty_o = (level_q == '0);
  assign r_acc     = r_en_i & ~r_empty_o;
  assign r_valid_o = r_valid_q;
  assign lvl_inc   = w_acc;
  assign lvl_dec   = r_acc;

  always_comb begin
    r_valid_d = r_acc;
  end

  // Reset wins over a read issued in the same cycle, discarding it.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_valid_q <= 1'b0;
    end else if (rst_i) begin
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= r_valid_d;
    end
  end
`endif

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (w_acc) begin
      wptr_d = wptr_q + C_ONE;
    end
    if (r_acc) begin
      rptr_d = rptr_q + C_ONE;
    end
    case ({lvl_inc, lvl_dec})
      2'b10:   level_d = level_q + C_ONE;
      2'b01:   level_d = level_q - C_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule
`default_nettype wire
